// File: rtl/sigma_delta_decimator.sv
// Second-order CIC (sinc^2) decimator for a 1-bit sigma-delta stream.
// Emits one gain-normalised, saturated signed sample per 2**DEC_LOG2 accepted bits.
module sigma_delta_decimator #(
   parameter int BW       = 16,
   parameter int DEC_LOG2 = 5,
   parameter int INV_POL  = 0
) (
   input  logic                 clk,
   input  logic                 rst_i,
   input  logic                 bit_i,
   input  logic                 bit_valid_i,
   output logic signed [BW-1:0] dout_o,
   output logic                 dout_valid_o,
   output logic                 sat_o
);

   localparam int W = 2 + 2 * DEC_LOG2;
   localparam int S = BW - 1 - 2 * DEC_LOG2;

   logic                pol;
   logic signed [W-1:0] x;
   logic signed [W-1:0] int1;
   logic signed [W-1:0] int2;
   logic signed [W-1:0] int2_d;
   logic signed [W-1:0] c1;
   logic signed [W-1:0] c1_d;
   logic signed [W-1:0] c2;
   logic [DEC_LOG2-1:0] cnt;
   logic                stb0;
   logic                stb1;
   logic signed [BW:0]  scaled;
   logic signed [BW-1:0] clamped;
   logic                clip_hi;

   assign pol = (INV_POL != 0);
   assign x   = (bit_i ^ pol) ? W'(1) : '1;

   // Integrator and comb arithmetic wraps modulo 2**W on purpose; the
   // final comb difference is exact as long as |c2| <= R**2 fits in W bits.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         int1 <= '0;
         int2 <= '0;
         cnt  <= '0;
         stb0 <= 1'b0;
      end else if (bit_valid_i) begin
         int1 <= int1 + x;
         int2 <= int2 + int1;
         cnt  <= cnt + 1'b1;
         stb0 <= &cnt;
      end else begin
         stb0 <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         int2_d <= '0;
         c1     <= '0;
         stb1   <= 1'b0;
      end else begin
         stb1 <= stb0;
         if (stb0) begin
            c1     <= int2 - int2_d;
            int2_d <= int2;
         end
      end
   end

   assign c2 = c1 - c1_d;

   // W + S == BW + 1, so the shifted value never loses bits before clamping.
   assign scaled = (BW + 1)'(c2) <<< S;

   always_comb begin
      clamped = scaled[BW-1:0];
      clip_hi = 1'b0;
      if (scaled[BW] != scaled[BW-1]) begin
         if (!scaled[BW]) begin
            clamped = {1'b0, {(BW - 1){1'b1}}};
            clip_hi = 1'b1;
         end else begin
            clamped = {1'b1, {(BW - 1){1'b0}}};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         c1_d         <= '0;
         dout_o       <= '0;
         dout_valid_o <= 1'b0;
         sat_o        <= 1'b0;
      end else if (stb1) begin
         c1_d         <= c1;
         dout_o       <= clamped;
         dout_valid_o <= 1'b1;
         sat_o        <= clip_hi;
      end else begin
         dout_valid_o <= 1'b0;
         sat_o        <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Bench for sigma_delta_decimator: directed pattern table, mid-frame reset,
// and random streams checked against a closed-form sinc^2 reference.
module tb_sigma_delta_decimator;

   localparam int BW = 16;
   localparam int DL = 5;
   localparam int R  = 32;
   localparam int S  = BW - 1 - 2 * DL;

   logic                 clk = 1'b0;
   logic                 rst_i;
   logic                 bit_i;
   logic                 bit_valid_i;
   logic signed [BW-1:0] dout_o;
   logic                 dout_valid_o;
   logic                 sat_o;

   sigma_delta_decimator #(.BW(BW), .DEC_LOG2(DL), .INV_POL(0)) dut (
      .clk          (clk),
      .rst_i        (rst_i),
      .bit_i        (bit_i),
      .bit_valid_i  (bit_valid_i),
      .dout_o       (dout_o),
      .dout_valid_o (dout_valid_o),
      .sat_o        (sat_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              kind;
      int              gap;
      int              nbits;
      int              nexp;
      logic [3:0][31:0] d;
      logic [3:0]      s;
   } vec_t;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int hold_err = 0;
   logic prev_v = 1'b0;
   logic signed [BW-1:0] last_d = '0;

   int xs[$];
   int exp_t[$];
   int got_d[$];
   int got_s[$];
   int got_t[$];
   int exp_d[$];
   int exp_s[$];

   vec_t tbl[5];

   task automatic chk(input string name, input int got, input int expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, got, expv);
      end
   endtask

   task automatic step(input logic b, input logic v, input logic r);
      bit_i       = b;
      bit_valid_i = v;
      rst_i       = r;
      @(posedge clk);
      #1;
      cyc++;
      if (r) begin
         last_d = '0;
         prev_v = 1'b0;
      end else begin
         if (v) begin
            xs.push_back(b ? 1 : -1);
            if (xs.size() % R == 0) exp_t.push_back(cyc + 2);
         end
         if (dout_valid_o) begin
            got_d.push_back(int'(dout_o));
            got_s.push_back(int'(sat_o));
            got_t.push_back(cyc);
            if (prev_v) hold_err++;
            last_d = dout_o;
         end else if (dout_o !== last_d || sat_o !== 1'b0) begin
            hold_err++;
         end
         prev_v = dout_valid_o;
      end
   endtask

   task automatic clear_log();
      xs.delete();
      exp_t.delete();
      got_d.delete();
      got_s.delete();
      got_t.delete();
      hold_err = 0;
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      clear_log();
   endtask

   // Second integrator value after n accepted samples, in exact arithmetic.
   function automatic longint i2(input int n);
      longint acc = 0;
      if (n <= 0) return 0;
      for (int j = 0; j < n; j++) acc += longint'(n - 1 - j) * longint'(xs[j]);
      return acc;
   endfunction

   task automatic model();
      longint c2;
      longint v;
      exp_d.delete();
      exp_s.delete();
      for (int m = 1; m <= xs.size() / R; m++) begin
         c2 = i2(m * R) - 2 * i2((m - 1) * R) + i2((m - 2) * R);
         v  = c2 * (64'sd1 << S);
         if (v > 32767) begin
            exp_d.push_back(32767);
            exp_s.push_back(1);
         end else if (v < -32768) begin
            exp_d.push_back(-32768);
            exp_s.push_back(0);
         end else begin
            exp_d.push_back(int'(v));
            exp_s.push_back(0);
         end
      end
   endtask

   task automatic finish_case(input string tag);
      repeat (4) step(1'b0, 1'b0, 1'b0);
      model();
      chk({tag, "_count"}, got_d.size(), exp_d.size());
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
         chk($sformatf("%s_dout%0d", tag, i), got_d[i], exp_d[i]);
         chk($sformatf("%s_sat%0d", tag, i), got_s[i], exp_s[i]);
         chk($sformatf("%s_time%0d", tag, i), got_t[i], exp_t[i]);
      end
      chk({tag, "_hold_width"}, hold_err, 0);
   endtask

   function automatic logic pat_bit(input int kind, input int i);
      case (kind)
         0:       return 1'b1;
         1:       return 1'b0;
         2:       return (i % 2 == 0);
         default: return (i % 4 != 3);
      endcase
   endfunction

   function automatic vec_t mk(input int kind, input int gap, input int nbits, input int nexp,
                               input int a, input int b, input int c, input int d,
                               input logic [3:0] s);
      vec_t t;
      t.kind  = kind;
      t.gap   = gap;
      t.nbits = nbits;
      t.nexp  = nexp;
      t.d[0]  = 32'(a);
      t.d[1]  = 32'(b);
      t.d[2]  = 32'(c);
      t.d[3]  = 32'(d);
      t.s     = s;
      return t;
   endfunction

   initial begin
      rst_i       = 1'b1;
      bit_i       = 1'b0;
      bit_valid_i = 1'b0;

      tbl[0] = mk(0, 0,  96, 3,  15872,  32767,  32767,     0, 4'b0110);
      tbl[1] = mk(1, 0,  96, 3, -15872, -32768, -32768,     0, 4'b0000);
      tbl[2] = mk(2, 0,  96, 3,    512,      0,      0,     0, 4'b0000);
      tbl[3] = mk(3, 0, 128, 4,   8704,  16384,  16384, 16384, 4'b0000);
      tbl[4] = mk(0, 1,  96, 3,  15872,  32767,  32767,     0, 4'b0110);

      do_reset();
      chk("reset_dout", int'(dout_o), 0);
      chk("reset_valid", int'(dout_valid_o), 0);
      chk("reset_sat", int'(sat_o), 0);

      for (int k = 0; k < 5; k++) begin
         string tag;
         tag = $sformatf("vec%0d", k);
         do_reset();
         for (int i = 0; i < tbl[k].nbits; i++) begin
            if (tbl[k].gap != 0) step(~pat_bit(tbl[k].kind, i), 1'b0, 1'b0);
            step(pat_bit(tbl[k].kind, i), 1'b1, 1'b0);
         end
         finish_case(tag);
         chk({tag, "_tbl_count"}, got_d.size(), tbl[k].nexp);
         for (int i = 0; i < tbl[k].nexp && i < got_d.size(); i++) begin
            chk($sformatf("%s_tbl_dout%0d", tag, i), got_d[i], int'($signed(tbl[k].d[i])));
            chk($sformatf("%s_tbl_sat%0d", tag, i), got_s[i], int'(tbl[k].s[i]));
            if (i > 0)
               chk($sformatf("%s_spacing%0d", tag, i), got_t[i] - got_t[i-1], R * (tbl[k].gap + 1));
         end
      end

      // Reset 20 bits into the second frame; the partial frame must vanish.
      do_reset();
      for (int i = 0; i < R + 20; i++) step(1'b1, 1'b1, 1'b0);
      chk("midrst_first_frame", got_d.size(), 1);
      step(1'b1, 1'b1, 1'b1);
      chk("midrst_dout_cleared", int'(dout_o), 0);
      clear_log();
      for (int i = 0; i < 2 * R; i++) step(1'b1, 1'b1, 1'b0);
      finish_case("midrst");
      chk("midrst_tbl_count", got_d.size(), 2);
      if (got_d.size() == 2) begin
         chk("midrst_tbl_dout0", got_d[0], 15872);
         chk("midrst_tbl_dout1", got_d[1], 32767);
         chk("midrst_tbl_sat1", got_s[1], 1);
      end

      // Reset landing just after a frame's last bit drops the in-flight sample.
      do_reset();
      for (int i = 0; i < R; i++) step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      clear_log();
      repeat (4) step(1'b0, 1'b0, 1'b0);
      chk("inflight_dropped", got_d.size(), 0);

      for (int run = 0; run < 6; run++) begin
         int p;
         int nfr;
         p   = $urandom_range(0, 100);
         nfr = $urandom_range(3, 5);
         do_reset();
         for (int i = 0; i < nfr * R; i++) begin
            for (int g = 0; g < 3 && $urandom_range(0, 3) == 0; g++)
               step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            step(($urandom_range(0, 99) < p), 1'b1, 1'b0);
         end
         finish_case($sformatf("rand%0d", run));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
